// File: rtl/instruction_cache.sv
// rtl/instruction_cache.sv - direct-mapped read-only instruction cache with block refill
module instruction_cache #(
    parameter int ADDR_BITS  = 10,
    parameter int INDEX_BITS = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 read,
    input  logic [ADDR_BITS-1:0] address,
    output logic [31:0]          readinst,
    output logic                 busywait,
    output logic                 mem_read,
    output logic [ADDR_BITS-5:0] mem_address,
    input  logic [127:0]         mem_readinst,
    input  logic                 mem_busywait
);

    localparam int TAG_BITS = ADDR_BITS - 4 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t state_q, state_next;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [127:0]        data_q [LINES];
    logic                seen_busy_q;
    logic [31:0]         readinst_q;

    logic [INDEX_BITS-1:0] addr_index;
    logic [TAG_BITS-1:0]   addr_tag;
    logic [1:0]            addr_offset;
    logic [127:0]          line_data;
    logic [31:0]           hit_word;
    logic                  hit;
    logic                  serve_hit;
    logic                  unused_byte_offset;

    assign addr_offset        = address[3:2];
    assign addr_index         = address[3+INDEX_BITS:4];
    assign addr_tag           = address[ADDR_BITS-1:4+INDEX_BITS];
    assign unused_byte_offset = ^address[1:0];

    assign line_data   = data_q[addr_index];
    assign hit         = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);
    assign serve_hit   = (state_q == IDLE) && read && hit;
    assign mem_address = address[ADDR_BITS-1:4];

    // Word select within the indexed line
    always_comb begin
        hit_word = line_data[31:0];
        case (addr_offset)
            2'd0: hit_word = line_data[31:0];
            2'd1: hit_word = line_data[63:32];
            2'd2: hit_word = line_data[95:64];
            2'd3: hit_word = line_data[127:96];
            default: hit_word = line_data[31:0];
        endcase
    end

    // A hit is served combinationally; otherwise the last delivered word is held
    assign readinst = serve_hit ? hit_word : readinst_q;

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // FSM next-state and handshake outputs
    always_comb begin
        state_next = state_q;
        busywait   = 1'b0;
        mem_read   = 1'b0;
        case (state_q)
            IDLE: begin
                if (read && !hit) begin
                    busywait   = 1'b1;
                    state_next = MEM_READ;
                end
            end
            MEM_READ: begin
                mem_read = 1'b1;
                busywait = 1'b1;
                // Only a busy-then-idle memory marks the block as delivered
                if (seen_busy_q && !mem_busywait) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                busywait   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Remember that memory has gone busy during the current refill
    always_ff @(posedge clock) begin
        if (reset) begin
            seen_busy_q <= 1'b0;
        end else if (state_q == MEM_READ && mem_busywait) begin
            seen_busy_q <= 1'b1;
        end else if (state_q == UPDATE) begin
            seen_busy_q <= 1'b0;
        end
    end

    // Valid bits: cleared by reset, set when a refilled block is installed
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else if (state_q == UPDATE) begin
            valid_q[addr_index] <= 1'b1;
        end
    end

    // Tag and data storage written only at the end of UPDATE
    always_ff @(posedge clock) begin
        if (!reset && state_q == UPDATE) begin
            tag_q[addr_index]  <= addr_tag;
            data_q[addr_index] <= mem_readinst;
        end
    end

    // Hold register for readinst while the CPU is not fetching
    always_ff @(posedge clock) begin
        if (reset) begin
            readinst_q <= 32'd0;
        end else if (serve_hit) begin
            readinst_q <= hit_word;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// tb/tb_instruction_cache.sv - scoreboard bench for instruction_cache with behavioural memory
module tb_instruction_cache;

    logic         clock = 1'b0;
    logic         reset;
    logic         read;
    logic [9:0]   address;
    logic [31:0]  readinst;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readinst = '0;
    logic         mem_busywait = 1'b0;

    instruction_cache #(.ADDR_BITS(10), .INDEX_BITS(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .readinst     (readinst),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readinst (mem_readinst),
        .mem_busywait (mem_busywait)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] word;
        int          stall;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb_e;
    logic [31:0] mem_words [256];
    int          resident  [8];
    int          errors = 0;
    int          checks = 0;
    int          mem_delay = 0;
    int          mem_busy  = 1;
    int          stall_cnt = 0;
    logic [31:0] last_word = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Memory: after seeing mem_read, stays idle mem_delay cycles, busy mem_busy cycles, then presents the block
    int         mst = 0;
    int         mcnt = 0;
    logic [5:0] mblk = '0;
    always @(posedge clock) begin
        if (reset) begin
            mst          <= 0;
            mem_busywait <= 1'b0;
        end else begin
            case (mst)
                0: if (mem_read) begin
                    mblk <= mem_address;
                    if (mem_delay == 0) begin
                        mem_busywait <= 1'b1;
                        mcnt         <= mem_busy - 1;
                        mst          <= 2;
                    end else begin
                        mcnt <= mem_delay - 1;
                        mst  <= 1;
                    end
                end
                1: if (mcnt == 0) begin
                    mem_busywait <= 1'b1;
                    mcnt         <= mem_busy - 1;
                    mst          <= 2;
                end else begin
                    mcnt <= mcnt - 1;
                end
                2: if (mcnt == 0) begin
                    mem_busywait <= 1'b0;
                    mem_readinst <= {mem_words[int'(mblk)*4+3], mem_words[int'(mblk)*4+2],
                                     mem_words[int'(mblk)*4+1], mem_words[int'(mblk)*4]};
                    mst          <= 3;
                end else begin
                    mcnt <= mcnt - 1;
                end
                default: if (!mem_read) mst <= 0;
            endcase
        end
    end

    // Monitor: counts stall cycles and checks each delivered instruction against the scoreboard
    always @(negedge clock) begin
        if (reset) begin
            stall_cnt = 0;
        end else begin
            if (mem_read) chk("mem_address", {26'd0, mem_address}, {26'd0, address[9:4]});
            if (read) begin
                if (busywait) begin
                    stall_cnt++;
                end else begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_delivery", 32'd1, 32'd0);
                    end else begin
                        sb_e = sb_q.pop_front();
                        chk("readinst", readinst, sb_e.word);
                        chk("stall_cycles", stall_cnt, sb_e.stall);
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 8; i++) resident[i] = -1;
    endtask

    // Issue one fetch: the model says hit or miss from block residency; memory defines the word
    task automatic do_fetch(input logic [9:0] a);
        int   blk;
        int   idx;
        bit   miss;
        bit   done;
        exp_t e;
        blk  = int'(a[9:4]);
        idx  = blk % 8;
        miss = (resident[idx] != blk);
        resident[idx] = blk;
        e.word  = mem_words[int'(a[9:2])];
        e.stall = miss ? (mem_delay + mem_busy + 4) : 0;
        sb_q.push_back(e);
        last_word = e.word;
        address = a;
        read    = 1'b1;
        done    = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clock);
            if (!busywait) done = 1'b1;
        end
        if (!done) begin
            chk("fetch_timeout", 32'd1, 32'd0);
            finish_run();
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            read    = 1'b0;
            address = 10'($urandom);
            @(negedge clock);
            chk("idle_mem_read", {31'd0, mem_read}, 32'd0);
            chk("idle_busywait", {31'd0, busywait}, 32'd0);
            chk("idle_readinst_hold", readinst, last_word);
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_words[i] = $urandom;
        mem_words[0] = 32'h00010003;
        mem_words[1] = 32'h00020002;
        mem_words[2] = 32'h00020118;
        mem_words[3] = 32'h0001005A;
        clear_model();
        reset   = 1'b1;
        read    = 1'b0;
        address = '0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("reset_readinst", readinst, 32'd0);
        chk("reset_busywait", {31'd0, busywait}, 32'd0);
        chk("reset_mem_read", {31'd0, mem_read}, 32'd0);
        @(posedge clock);
        #1;

        // Directed: block 0 miss then hits, conflict eviction, re-miss
        mem_delay = 0;
        mem_busy  = 3;
        do_fetch(10'h000);
        do_fetch(10'h004);
        do_fetch(10'h008);
        do_fetch(10'h00C);
        do_fetch(10'h080);
        do_fetch(10'h000);
        idle_cycles(4);

        // Reset during an in-flight refill of 0x010
        address = 10'h010;
        read    = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        read  = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        clear_model();
        last_word = 32'd0;
        @(negedge clock);
        chk("abort_mem_read", {31'd0, mem_read}, 32'd0);
        chk("abort_busywait", {31'd0, busywait}, 32'd0);
        chk("abort_readinst", readinst, 32'd0);
        @(posedge clock);
        #1;
        do_fetch(10'h010);
        do_fetch(10'h000);

        // Memory stays idle before going busy: the low busywait must not end the refill
        mem_delay = 2;
        mem_busy  = 2;
        do_fetch(10'h234);
        do_fetch(10'h238);
        idle_cycles(3);
        do_fetch(10'h23C);

        // Randomized fetches over a small block set to mix hits and conflict misses
        for (int n = 0; n < 150; n++) begin
            mem_delay = $urandom_range(0, 2);
            mem_busy  = $urandom_range(1, 4);
            do_fetch({6'($urandom_range(0, 23)), 4'($urandom)});
            if ($urandom_range(0, 7) == 0) idle_cycles(1);
        end

        read = 1'b0;
        @(negedge clock);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        finish_run();
    end

endmodule
